// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a single-outstanding command/response handshake into
// SETUP/ACCESS transfers, honours pready wait states and aborts stalled transfers.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
    TO_EN ? TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1) : {TO_CNT_WIDTH{1'b0}};

  state_e                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [TO_CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    to_cnt_d      = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          to_cnt_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          // Watchdog abort: report a zero payload flagged as timed out.
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: zero-wait, wait-state, timeout,
// back-to-back, reset mid-transfer and spurious-pready scenarios.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .TO_CNT_WIDTH(8)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Runs one transfer from IDLE. waits < 0 means pready never rises.
  // rsp_cyc counts cycles after the accept edge (-1 if no response).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rd, input logic idle_ready,
                      output int setup_cyc, output int access_cyc, output int rsp_cyc,
                      output logic [31:0] r_data, output logic r_to,
                      output logic addr_ok);
    setup_cyc = 0; access_cyc = 0; rsp_cyc = -1; r_data = '0; r_to = 1'b0; addr_ok = 1'b1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = idle_ready;
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEE0; cmd_wdata = 32'hFFFF_FFFF; cmd_write = ~wr;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (psel) begin
        if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) addr_ok = 1'b0;
        if (!penable) setup_cyc++;
        else access_cyc++;
      end
      if (rsp_valid) begin
        rsp_cyc = cyc; r_data = rsp_rdata; r_to = rsp_timeout;
        break;
      end
      if (penable) begin
        pready = (waits >= 0) && (access_cyc > waits);
        prdata = pready ? rd : 32'hBAD0_0000 + 32'(access_cyc);
      end else begin
        pready = idle_ready;
        prdata = 32'hBAD1_1111;
      end
      tick();
    end
    pready = 1'b0;
    $display("xfer wr=%0b addr=%h setup=%0d access=%0d rsp_at=%0d rdata=%h to=%0b",
             wr, addr, setup_cyc, access_cyc, rsp_cyc, r_data, r_to);
  endtask

  task automatic test_reset();
    preset = 1'b1;
    tick(); tick();
    preset = 1'b0;
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {psel, penable, pwrite, rsp_valid, rsp_timeout});
    end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h want 0", paddr, pwdata, rsp_rdata);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    int s, a, r; logic [31:0] d; logic t, ok;
    xfer(1'b1, 32'h0C, 32'h3, 0, 32'h0, 1'b1, s, a, r, d, t, ok);
    checks++;
    if (s !== 1 || a !== 1) begin
      errors++; $display("FAIL wr0_phases got setup=%0d access=%0d want 1 1", s, a);
    end
    checks++;
    if (r !== 3) begin
      errors++; $display("FAIL wr0_latency got %0d want 3", r);
    end
    checks++;
    if (d !== 32'h0 || t !== 1'b0 || ok !== 1'b1) begin
      errors++; $display("FAIL wr0_rsp got rdata=%h to=%b bus_ok=%b want 0 0 1", d, t, ok);
    end
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr0_bus_idle got psel=%b pen=%b rdy=%b want 0 0 1", psel, penable, cmd_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr0_rsp_pulse got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    int s, a, r; logic [31:0] d; logic t, ok;
    xfer(1'b0, 32'h20, 32'h0, 2, 32'h55, 1'b0, s, a, r, d, t, ok);
    checks++;
    if (a !== 3 || r !== 5) begin
      errors++; $display("FAIL rd2_timing got access=%0d rsp_at=%0d want 3 5", a, r);
    end
    checks++;
    if (d !== 32'h55 || t !== 1'b0 || ok !== 1'b1) begin
      errors++; $display("FAIL rd2_rsp got rdata=%h to=%b bus_ok=%b want 55 0 1", d, t, ok);
    end
    tick();
    checks++;
    if (rsp_rdata !== 32'h55 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd2_hold got rdata=%h valid=%b want 55 0", rsp_rdata, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    int s, a, r; logic [31:0] d; logic t, ok;
    xfer(1'b0, 32'h14, 32'h0, -1, 32'h0, 1'b0, s, a, r, d, t, ok);
    checks++;
    if (a !== 16 || r !== 18) begin
      errors++; $display("FAIL to_cycles got access=%0d rsp_at=%0d want 16 18", a, r);
    end
    checks++;
    if (d !== 32'h0 || t !== 1'b1 || psel !== 1'b0) begin
      errors++; $display("FAIL to_rsp got rdata=%h to=%b psel=%b want 0 1 0", d, t, psel);
    end
    tick();
    xfer(1'b0, 32'h14, 32'h0, 0, 32'hA5A5_0001, 1'b0, s, a, r, d, t, ok);
    checks++;
    if (d !== 32'hA5A5_0001 || t !== 1'b0 || r !== 3) begin
      errors++; $display("FAIL to_recover got rdata=%h to=%b rsp_at=%0d want a5a50001 0 3", d, t, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] setup_addr [4];
    logic [31:0] setup_data [4];
    int setup_at [4];
    int rsp_at [4];
    int idx, n_setup, n_rsp;
    logic fire;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    idx = 0; n_setup = 0; n_rsp = 0;
    pready = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cmd_valid = (idx < 3);
      cmd_write = 1'b1;
      cmd_addr  = (idx < 3) ? addrs[idx] : 32'hFFFF_FFF0;
      cmd_wdata = 32'h11 * 32'(idx + 1);
      fire = cmd_valid && cmd_ready;
      tick();
      if (fire) idx++;
      if (psel && !penable && n_setup < 4) begin
        setup_addr[n_setup] = paddr; setup_data[n_setup] = pwdata; setup_at[n_setup] = cyc; n_setup++;
      end
      if (rsp_valid && n_rsp < 4) begin
        rsp_at[n_rsp] = cyc; n_rsp++;
      end
    end
    cmd_valid = 1'b0; pready = 1'b0;
    $display("b2b accepted=%0d setups=%0d rsps=%0d", idx, n_setup, n_rsp);
    checks++;
    if (idx !== 3 || n_setup !== 3 || n_rsp !== 3) begin
      errors++; $display("FAIL b2b_count got acc=%0d setup=%0d rsp=%0d want 3 3 3", idx, n_setup, n_rsp);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (setup_addr[i] !== addrs[i] || setup_data[i] !== 32'h11 * 32'(i + 1)) begin
          errors++; $display("FAIL b2b_addr%0d got %h/%h want %h/%h", i, setup_addr[i], setup_data[i], addrs[i], 32'h11 * 32'(i + 1));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (setup_at[i] !== rsp_at[i-1] + 1) begin
          errors++; $display("FAIL b2b_gap%0d got setup_at=%0d want %0d", i, setup_at[i], rsp_at[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int s, a, r, n_rsp; logic [31:0] d; logic t, ok;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got psel=%b pen=%b want 1 1", psel, penable);
    end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop got psel=%b pen=%b rsp=%b want 0 0 0", psel, penable, rsp_valid);
    end
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      pready = 1'b1;
      tick();
      if (i == 0) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++; $display("FAIL rst_mid_ready got %b want 1", cmd_ready);
        end
      end
      if (rsp_valid) n_rsp++;
    end
    pready = 1'b0;
    checks++;
    if (n_rsp !== 0) begin
      errors++; $display("FAIL rst_mid_norsp got %0d pulses want 0", n_rsp);
    end
    xfer(1'b1, 32'h40, 32'hCAFE, 1, 32'h0, 1'b0, s, a, r, d, t, ok);
    checks++;
    if (r !== 4 || t !== 1'b0 || d !== 32'h0 || ok !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after got rsp_at=%0d to=%b rdata=%h ok=%b want 4 0 0 1", r, t, d, ok);
    end
  endtask

  task automatic test_spurious_pready();
    int s, a, r, bad; logic [31:0] d; logic t, ok;
    bad = 0;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (psel !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL spur_idle got %0d bad cycles want 0", bad);
    end
    xfer(1'b0, 32'h08, 32'h0, 0, 32'h0000_7777, 1'b1, s, a, r, d, t, ok);
    checks++;
    if (s !== 1 || a !== 1 || r !== 3 || d !== 32'h7777) begin
      errors++; $display("FAIL spur_setup got setup=%0d access=%0d rsp_at=%0d rdata=%h want 1 1 3 7777", s, a, r, d);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_spurious_pready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
